// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the MM-stage SRAM responder.
// State encodings, strobe bundle and its idle value live here.
package sram_ctrl_pkg;

   localparam int SRAM_ADDR_W  = 20;
   localparam int SRAM_RD_WAIT = 2;
   localparam int SRAM_WR_WAIT = 2;

   typedef enum logic [1:0] {
      SRAM_ST_IDLE = 2'd0,
      SRAM_ST_RD   = 2'd1,
      SRAM_ST_WR   = 2'd2,
      SRAM_ST_DONE = 2'd3
   } sram_st_e;

   typedef struct packed {
      logic       ce_n;
      logic       oe_n;
      logic       we_n;
      logic [3:0] be_n;
      logic       data_oe;
   } sram_strb_t;

   localparam sram_strb_t SRAM_STRB_RST = '{
      ce_n:    1'b1,
      oe_n:    1'b1,
      we_n:    1'b1,
      be_n:    4'hf,
      data_oe: 1'b0
   };

   function automatic int sram_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// MM-stage memory access bundle between the pipeline and sram_ctrl.
// master = MM stage, slave = SRAM controller.
interface sram_ctrl_if;

   logic [31:0] mem_access_addr;
   logic        mem_access_read;
   logic        mem_access_write;
   logic [31:0] mem_access_data_out;
   logic [3:0]  mem_byte_en;
   logic [31:0] mem_access_data_in;
   logic        mem_stall;

   modport master (
      output mem_access_addr,
      output mem_access_read,
      output mem_access_write,
      output mem_access_data_out,
      output mem_byte_en,
      input  mem_access_data_in,
      input  mem_stall
   );

   modport slave (
      input  mem_access_addr,
      input  mem_access_read,
      input  mem_access_write,
      input  mem_access_data_out,
      input  mem_byte_en,
      output mem_access_data_in,
      output mem_stall
   );

endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM responder with programmable read/write wait states.
// Define SRAM_CTRL_WRITE_BUFFER_EN for posted (non-stalling) writes.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W  = SRAM_ADDR_W,
   parameter int RD_WAIT = SRAM_RD_WAIT,
   parameter int WR_WAIT = SRAM_WR_WAIT
) (
   input  logic              clk,
   input  logic              rst,
   sram_ctrl_if.slave        mem,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_data_o,
   output logic              sram_data_oe,
   input  logic [31:0]       sram_data_i,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [3:0]        sram_be_n
);

   localparam int CNT_W = $clog2(sram_max(RD_WAIT, WR_WAIT)) + 1;
   localparam logic [CNT_W-1:0] RD_LD = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LD = CNT_W'(WR_WAIT - 1);

`ifdef SRAM_CTRL_WRITE_BUFFER_EN
   localparam bit WR_POSTED = 1'b1;
`else
   localparam bit WR_POSTED = 1'b0;
`endif

   sram_st_e          st_q, st_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   sram_strb_t        strb_q, strb_d;

   logic req_vld;
   logic req_wr;
   logic unused_addr;

   assign req_vld = mem.mem_access_read | mem.mem_access_write;
   assign req_wr  = mem.mem_access_write;

   assign unused_addr = ^{mem.mem_access_addr[1:0],
                          mem.mem_access_addr[31:ADDR_W+2]};

   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      strb_d  = strb_q;
      unique case (st_q)
         SRAM_ST_IDLE: begin
            if (req_vld) begin
               addr_d      = mem.mem_access_addr[ADDR_W+1:2];
               wdata_d     = mem.mem_access_data_out;
               strb_d      = SRAM_STRB_RST;
               strb_d.ce_n = 1'b0;
               if (req_wr) begin
                  st_d           = SRAM_ST_WR;
                  cnt_d          = WR_LD;
                  strb_d.we_n    = 1'b0;
                  strb_d.be_n    = ~mem.mem_byte_en;
                  strb_d.data_oe = 1'b1;
               end else begin
                  st_d        = SRAM_ST_RD;
                  cnt_d       = RD_LD;
                  strb_d.oe_n = 1'b0;
                  strb_d.be_n = 4'h0;
               end
            end
         end
         SRAM_ST_RD: begin
            if (cnt_q == '0) begin
               rdata_d = sram_data_i;
               st_d    = SRAM_ST_DONE;
               strb_d  = SRAM_STRB_RST;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SRAM_ST_WR: begin
            if (cnt_q == '0) begin
               // posted writes skip DONE: nobody is waiting on them
               st_d   = WR_POSTED ? SRAM_ST_IDLE : SRAM_ST_DONE;
               strb_d = SRAM_STRB_RST;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SRAM_ST_DONE: begin
            st_d = SRAM_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= SRAM_ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         strb_q  <= SRAM_STRB_RST;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         strb_q  <= strb_d;
      end
   end

   assign mem.mem_stall = ((st_q == SRAM_ST_IDLE) && req_vld &&
                           !(req_wr && WR_POSTED)) ||
                          (st_q == SRAM_ST_RD) ||
                          (st_q == SRAM_ST_WR);

   assign mem.mem_access_data_in = rdata_q;

   assign sram_addr    = addr_q;
   assign sram_data_o  = wdata_q;
   assign sram_data_oe = strb_q.data_oe;
   assign sram_ce_n    = strb_q.ce_n;
   assign sram_oe_n    = strb_q.oe_n;
   assign sram_we_n    = strb_q.we_n;
   assign sram_be_n    = strb_q.be_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl against a transaction-level memory model.
// Honors SRAM_CTRL_WRITE_BUFFER_EN for expected stall lengths.
module tb_sram_ctrl;
   import sram_ctrl_pkg::*;

   localparam int AW  = SRAM_ADDR_W;
   localparam int RDW = SRAM_RD_WAIT;
   localparam int WRW = SRAM_WR_WAIT;
`ifdef SRAM_CTRL_WRITE_BUFFER_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_data_o;
   logic          sram_data_oe;
   logic [31:0]   sram_data_i;
   logic          sram_ce_n;
   logic          sram_oe_n;
   logic          sram_we_n;
   logic [3:0]    sram_be_n;

   sram_ctrl_if mif();

   sram_ctrl #(
      .ADDR_W  (AW),
      .RD_WAIT (RDW),
      .WR_WAIT (WRW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem          (mif),
      .sram_addr    (sram_addr),
      .sram_data_o  (sram_data_o),
      .sram_data_oe (sram_data_oe),
      .sram_data_i  (sram_data_i),
      .sram_ce_n    (sram_ce_n),
      .sram_oe_n    (sram_oe_n),
      .sram_we_n    (sram_we_n),
      .sram_be_n    (sram_be_n)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEAD_BEEF;
      return {8'(i), 8'h5a, 8'(i * 7), 8'hc3};
   endfunction

   // board SRAM: 64 words, asynchronous read, byte-masked write
   logic [31:0] sram_mem [0:63];

   initial begin
      for (int i = 0; i < 64; i++) sram_mem[i] <= init_word(i);
   end

   assign sram_data_i = (!sram_ce_n && !sram_oe_n) ?
                        sram_mem[sram_addr[5:0]] : 32'h0;

   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n && sram_data_oe) begin
         for (int b = 0; b < 4; b++) begin
            if (!sram_be_n[b])
               sram_mem[sram_addr[5:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
         end
      end
   end

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] ref_mem [0:63];
   logic [31:0] last_rd = 32'h0;
   int          pend_wr = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      mif.mem_access_read  = 1'b0;
      mif.mem_access_write = 1'b0;
   endtask

   task automatic xact(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input int gap);
      int            pend;
      int            exp_stall;
      int            nst;
      int            n_we;
      int            n_oe;
      bit            done;
      bit            is_wr;
      logic [5:0]    wi;
      logic [AW-1:0] exp_sa;
      logic [3:0]    exp_be_n;
      logic [31:0]   exp_rd;

      is_wr    = wr;
      wi       = a[7:2];
      exp_sa   = a[AW+1:2];
      exp_be_n = ~be;
      pend     = pend_wr - gap;
      if (pend < 0) pend = 0;
      if (is_wr) exp_stall = POSTED ? pend : WRW + 1;
      else       exp_stall = pend + RDW + 1;

      @(posedge clk); #1;
      idle_inputs();
      repeat (gap) begin
         @(posedge clk); #1;
      end
      mif.mem_access_addr     = a;
      mif.mem_access_data_out = d;
      mif.mem_byte_en         = be;
      mif.mem_access_read     = rd;
      mif.mem_access_write    = wr;

      nst  = 0;
      n_we = 0;
      n_oe = 0;
      done = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (i >= pend) begin
            if (!sram_we_n) begin
               n_we++;
               chk("wr_addr", 32'(sram_addr), 32'(exp_sa));
               chk("wr_be_n", 32'(sram_be_n), 32'(exp_be_n));
               chk("wr_data", sram_data_o, d);
            end
            if (!sram_oe_n) begin
               n_oe++;
               chk("rd_addr", 32'(sram_addr), 32'(exp_sa));
               chk("rd_no_drive", 32'(sram_data_oe), 32'h0);
            end
         end
         if (mif.mem_stall) nst++;
         else done = 1'b1;
      end
      if (!done) chk("timeout", 32'h1, 32'h0);

      chk(is_wr ? "wr_stall" : "rd_stall", 32'(nst), 32'(exp_stall));
      if (is_wr) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[wi][8*b +: 8] = d[8*b +: 8];
         chk("wr_keeps_rdata", mif.mem_access_data_in, last_rd);
         if (!POSTED) chk("we_cycles", 32'(n_we), 32'(WRW));
         pend_wr = POSTED ? WRW : 0;
      end else begin
         exp_rd = ref_mem[wi];
         chk("rdata", mif.mem_access_data_in, exp_rd);
         chk("oe_cycles", 32'(n_oe), 32'(RDW));
         last_rd = exp_rd;
         pend_wr = 0;
      end
   endtask

   initial begin
      logic [31:0] ra;
      bit          rrd;
      bit          rwr;

      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      mif.mem_access_addr     = 32'h0;
      mif.mem_access_data_out = 32'h0;
      mif.mem_byte_en         = 4'h0;
      idle_inputs();

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_data_in", mif.mem_access_data_in, 32'h0);
      chk("rst_stall", 32'(mif.mem_stall), 32'h0);
      chk("rst_addr", 32'(sram_addr), 32'h0);
      chk("rst_data_o", sram_data_o, 32'h0);
      chk("rst_data_oe", 32'(sram_data_oe), 32'h0);
      chk("rst_strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
      chk("rst_be_n", 32'(sram_be_n), 32'hf);
      @(posedge clk); #1;
      rst = 1'b0;

      xact(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0);
      chk("rd_deadbeef", mif.mem_access_data_in, 32'hDEAD_BEEF);

      // reset while sitting in the second read wait cycle
      @(posedge clk); #1;
      mif.mem_access_addr  = 32'h0000_0040;
      mif.mem_access_read  = 1'b1;
      mif.mem_access_write = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      idle_inputs();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ce_n", 32'(sram_ce_n), 32'h1);
      chk("midrst_oe_n", 32'(sram_oe_n), 32'h1);
      chk("midrst_stall", 32'(mif.mem_stall), 32'h0);
      chk("midrst_data_in", mif.mem_access_data_in, 32'h0);
      chk("midrst_addr", 32'(sram_addr), 32'h0);
      last_rd = 32'h0;
      pend_wr = 0;

      xact(1'b0, 1'b1, 32'h0000_0020, 32'h1212_1212, 4'b0100, 0);
      xact(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 0);
      chk("byte2_written", 32'(sram_mem[8][23:16]), 32'h12);
      chk("byte1_kept", 32'(sram_mem[8][15:8]), 32'(ref_mem[8][15:8]));

      xact(1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 4'hf, 0);
      xact(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 0);

      for (int n = 0; n < 60; n++) begin
         ra  = 32'($urandom_range(0, 255));
         rrd = 1'($urandom_range(0, 1));
         rwr = rrd ? ($urandom_range(0, 3) == 0) : 1'b1;
         xact(rrd, rwr, ra, $urandom, 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 2)));
      end

      for (int i = 0; i < 64; i += 9)
         xact(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0, 1);

      @(posedge clk); #1;
      idle_inputs();
      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
